imem_loader: RTL
================

Name: imem_loader

Overview:
Boot-time writer for the byte-addressable instruction memory. It receives a framed program image as a byte stream over a valid/ready handshake and writes each payload byte to consecutive memory addresses starting at 0. It holds the core in reset until a complete, checksum-verified image has been written. It sits between the host byte link (UART receiver or bench) and the instruction memory write port.

Parameters:
ADDR_WIDTH, 8, byte address width of instruction memory
BYTE_WIDTH, 8, width of one memory byte and one stream byte
MAX_BYTES, 256, largest accepted payload length in bytes; must be ≤ 2**ADDR_WIDTH
TIMEOUT_CYCLES, 1000, maximum idle cycles between accepted bytes once a frame has started

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that arms the loader
in_data  in  BYTE_WIDTH  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts a byte this cycle
mem_we  out  1  memory byte write enable
mem_addr  out  ADDR_WIDTH  byte address for the write
mem_wdata  out  BYTE_WIDTH  byte written
busy  out  1  a frame is in progress
cpu_hold  out  1  keep the core in reset
done  out  1  image loaded and verified (sticky)
error  out  1  frame aborted (sticky)
err_code  out  2  0 none, 1 bad length, 2 timeout, 3 checksum mismatch

Behaviour:
- Frame format: LEN_HI, LEN_LO (16-bit big-endian byte count L), then L payload bytes, then 1 checksum byte. The checksum is the XOR of LEN_HI, LEN_LO and all payload bytes.
- Byte order: payload byte k is written to address k. The host sends each instruction MSB first, so the word at address a is {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
- Handshake: a transfer occurs on a rising edge with in_valid && in_ready. in_ready is combinational from state only, never from in_valid. in_ready = 1 in LEN_HI, LEN_LO, PAYLOAD and CHECK; otherwise 0.
- States and transitions:
  - IDLE → LEN_HI on start.
  - LEN_HI → LEN_LO on a transfer.
  - LEN_LO, on a transfer:
    - L > MAX_BYTES or L[1:0] ≠ 0 → ERROR, err_code = 1.
    - L = 0 → CHECK.
    - otherwise → PAYLOAD.
  - PAYLOAD: each transfer increments the byte counter. After the L-th byte → CHECK.
  - CHECK, on a transfer: checksum matches → DONE; mismatch → ERROR, err_code = 3.
  - DONE and ERROR → LEN_HI on start.
- start while busy is ignored.
- Write timing: mem_we, mem_addr and mem_wdata are registered and asserted exactly one cycle after the payload transfer. mem_we is high for one cycle per byte.
  - mem_addr = the counter value at acceptance, ADDR_WIDTH bits.
  - With back-to-back transfers, mem_we stays high for consecutive cycles.
  - No write is issued for length bytes or the checksum byte.
- Timeout:
  - The counter clears on every transfer and on entering LEN_HI.
  - It increments in LEN_LO, PAYLOAD and CHECK while no transfer occurs.
  - When it reaches TIMEOUT_CYCLES → ERROR, err_code = 2. LEN_HI waits indefinitely.
- Status outputs:
  - busy = 1 in LEN_HI, LEN_LO, PAYLOAD and CHECK.
  - done = 1 only in DONE.
  - error = 1 only in ERROR.
  - err_code holds its value until the next start, which clears it to 0.
- cpu_hold = 1 in every state except DONE. It deasserts in the cycle DONE is entered.
- Reset (any time, including mid-frame): state IDLE; cpu_hold = 1; in_ready, mem_we, busy, done, error = 0; err_code = 0; mem_addr and mem_wdata = 0; all counters and the checksum = 0. A partially written image is left in memory as is.

Decomposition:
- Shared package rvscc_pkg:
  - loader_state_t enum: IDLE, LEN_HI, LEN_LO, PAYLOAD, CHECK, DONE, ERROR.
  - loader_err_t codes: 2-bit, values 0–3.
  - BYTE_WIDTH constant.
- Natural sub-module: imem_loader_timeout, a loadable idle counter with clear, enable and expired outputs.
- Checksum and write-port registers stay in the top module.

Test Plan:
- Basic load:
  - Stimulus: start; bytes 00 04 00 50 00 93 C7, back-to-back.
  - Response: four writes 00/50/00/93 to addresses 0..3 on consecutive cycles. Word 0 reads 0x00500093. done = 1, cpu_hold = 0, err_code = 0.
- Zero length:
  - Stimulus: start; bytes 00 00 00.
  - Response: no mem_we, done = 1.
- Bad length:
  - Stimulus: bytes 01 01 (257).
  - Response: ERROR, err_code = 1.
  - Stimulus: bytes 00 03.
  - Response: err_code = 1.
  - Both cases: no writes, cpu_hold stays 1.
- Checksum fault:
  - Stimulus: the basic-load frame with the last byte C6.
  - Response: 4 writes occur, then error = 1, err_code = 3, cpu_hold = 1.
  - Stimulus: start again with the good frame.
  - Response: done = 1, err_code cleared.
- Timeout and backpressure:
  - Stimulus: valid gaps of 3 cycles inside the basic-load frame.
  - Response: completes correctly.
  - Stimulus: stall for TIMEOUT_CYCLES after byte 3.
  - Response: err_code = 2.
- Reset mid-frame:
  - Stimulus: assert rst_n = 0 after 2 payload bytes.
  - Response: all outputs at reset values immediately, state IDLE. A following start and good frame loads normally.

Source files
------------

// File: rtl/rvscc_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package rvscc_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        PAYLOAD,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_CSUM    = 2'd3
    } loader_err_t;

endpackage

// File: rtl/imem_loader_timeout.sv
// Idle-cycle counter: counts while enabled, saturates at LIMIT and flags expiry.
module imem_loader_timeout #(
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int TW = $clog2(LIMIT + 1);

    logic [TW-1:0] count;

    assign expired = (count == TW'(LIMIT));

    // Clear has priority; hold at LIMIT so expiry stays asserted until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + TW'(1);
    end

endmodule

// File: rtl/imem_loader.sv
// Receives a framed program image byte stream, writes the payload to
// instruction memory from address 0 and releases the core once verified.
module imem_loader #(
    parameter int ADDR_WIDTH     = 8,
    parameter int BYTE_WIDTH     = rvscc_pkg::BYTE_WIDTH,
    parameter int MAX_BYTES      = 256,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BYTE_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);
    import rvscc_pkg::*;

    localparam int LW = 2 * BYTE_WIDTH;          // header length field width
    localparam int CW = $clog2(MAX_BYTES + 1);   // payload counter width
    localparam logic [LW-1:0] MAX_L = LW'(MAX_BYTES);

    loader_state_t         state, state_next;
    loader_err_t           err_next;
    logic                  xfer, arm, counting, expired;
    logic [BYTE_WIDTH-1:0] len_hi, csum;
    logic [LW-1:0]         len_full;
    logic [CW-1:0]         len, cnt, cnt_inc;

    assign in_ready = (state inside {LEN_HI, LEN_LO, PAYLOAD, CHECK});
    assign busy     = in_ready;
    assign done     = (state == DONE);
    assign error    = (state == ERROR);
    assign cpu_hold = (state != DONE);

    assign xfer     = in_valid && in_ready;
    assign arm      = start && !busy;
    assign counting = (state inside {LEN_LO, PAYLOAD, CHECK});
    assign len_full = {len_hi, in_data};
    assign cnt_inc  = cnt + CW'(1);

    // LEN_HI is excluded from counting, so the host may wait forever before the first byte.
    imem_loader_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (xfer || !counting),
        .enable  (counting && !xfer),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and abort cause; an accepted byte wins over a same-cycle expiry.
    always_comb begin
        state_next = state;
        err_next   = ERR_NONE;
        case (state)
            IDLE, DONE, ERROR: if (start) state_next = LEN_HI;
            LEN_HI:            if (xfer) state_next = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (len_full > MAX_L || len_full[1:0] != 2'b00) begin
                        state_next = ERROR;
                        err_next   = ERR_LEN;
                    end else if (len_full == '0) begin
                        state_next = CHECK;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end else if (expired) begin
                    state_next = ERROR;
                    err_next   = ERR_TIMEOUT;
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    if (cnt_inc == len) state_next = CHECK;
                end else if (expired) begin
                    state_next = ERROR;
                    err_next   = ERR_TIMEOUT;
                end
            end
            CHECK: begin
                if (xfer) begin
                    if (in_data == csum) begin
                        state_next = DONE;
                    end else begin
                        state_next = ERROR;
                        err_next   = ERR_CSUM;
                    end
                end else if (expired) begin
                    state_next = ERROR;
                    err_next   = ERR_TIMEOUT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Header capture, running checksum, payload counter, write port and error code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi    <= '0;
            len       <= '0;
            cnt       <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err_code  <= ERR_NONE;
        end else begin
            mem_we <= 1'b0;
            if (arm) begin
                len_hi   <= '0;
                len      <= '0;
                cnt      <= '0;
                csum     <= '0;
                err_code <= ERR_NONE;
            end
            if (xfer) begin
                case (state)
                    LEN_HI: begin
                        len_hi <= in_data;
                        csum   <= csum ^ in_data;
                    end
                    LEN_LO: begin
                        // Truncation only matters for lengths that abort anyway.
                        len  <= CW'(len_full);
                        cnt  <= '0;
                        csum <= csum ^ in_data;
                    end
                    PAYLOAD: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ADDR_WIDTH'(cnt);
                        mem_wdata <= in_data;
                        cnt       <= cnt_inc;
                        csum      <= csum ^ in_data;
                    end
                    default: ;
                endcase
            end
            if (state_next == ERROR && state != ERROR)
                err_code <= err_next;
        end
    end

endmodule
